haar_db_scheduler: RTL and testbench



---
 rtl/haar_db_scheduler_pkg.sv | 31 +++
 rtl/haar_db_scheduler_if.sv | 44 ++++
 rtl/haar_db_scheduler_rr_priority_pick.sv | 45 ++++
 rtl/haar_db_scheduler.sv | 163 ++++++++++++++++
 tb/tb_haar_db_scheduler.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/haar_db_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// haar_sched_pkg
// Shared definitions for the haar_database stream scheduler:
//   - state encoding of the pass FSM (IDLE -> REWIND -> STREAM -> RELEASE)
//   - default requester count and the derived grant-index width
// No ports; imported by the interface, the picker and the scheduler top.
// -----------------------------------------------------------------------------
package haar_sched_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REWIND  = 2'd1;
  localparam logic [1:0] ST_STREAM  = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    REWIND  = ST_REWIND,
    STREAM  = ST_STREAM,
    RELEASE = ST_RELEASE
  } state_t;

  localparam int NUM_RESIZE_DEF = 5;

  // Smallest width able to hold indices 0..n-1 (never below 1 bit).
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int IDX_W_DEF = idx_width(NUM_RESIZE_DEF);

endpackage

// File: rtl/haar_db_scheduler_if.sv
// -----------------------------------------------------------------------------
// haar_db_scheduler_if
// Bundle between the per-scale I2LBS engines / haar_database and the scheduler.
//   i_req[N]      level request per scale
//   i_reject[N]   per-scale early-exit strobe
//   i_db_end      end-of-database strobe
//   o_db_reset    one-cycle database rewind
//   o_db_en       database advance enable
//   o_grant[N]    one-hot stream owner, o_grant_idx its binary index
//   o_done[N]     completion pulse with o_pass (1 = full traversal)
//   o_timeout     watchdog abort pulse
//   o_busy        scheduler not idle
// Modports: slave = scheduler side, master = requester/database side.
// -----------------------------------------------------------------------------
interface haar_db_scheduler_if
  import haar_sched_pkg::*;
#(
  parameter int NUM_RESIZE = NUM_RESIZE_DEF,
  parameter int IDX_W      = IDX_W_DEF
);
  logic [NUM_RESIZE-1:0] i_req;
  logic [NUM_RESIZE-1:0] i_reject;
  logic                  i_db_end;
  logic                  o_db_reset;
  logic                  o_db_en;
  logic [NUM_RESIZE-1:0] o_grant;
  logic [IDX_W-1:0]      o_grant_idx;
  logic [NUM_RESIZE-1:0] o_done;
  logic                  o_pass;
  logic                  o_timeout;
  logic                  o_busy;

  modport slave (
    input  i_req, i_reject, i_db_end,
    output o_db_reset, o_db_en, o_grant, o_grant_idx, o_done, o_pass,
           o_timeout, o_busy
  );

  modport master (
    output i_req, i_reject, i_db_end,
    input  o_db_reset, o_db_en, o_grant, o_grant_idx, o_done, o_pass,
           o_timeout, o_busy
  );
endinterface

// File: rtl/haar_db_scheduler_rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin selector: finds the first set bit of req_i
// starting at ptr_i and searching upward, wrapping at N-1.
//   req_i[N]     request vector
//   ptr_i[IDX_W] search start; values >= N are treated as 0
//   gnt_o[N]     one-hot winner (0 when no request)
//   idx_o[IDX_W] binary index of the winner
//   any_o        at least one request pending
// -----------------------------------------------------------------------------
module rr_priority_pick #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int   start;
  int   j;
  logic found;

  always_comb begin
    start = (int'(ptr_i) < N) ? int'(ptr_i) : 0;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = start + i;
      if (j >= N) j = j - N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/haar_db_scheduler.sv
// -----------------------------------------------------------------------------
// haar_db_scheduler
// Time-shares the single haar_database stream between NUM_RESIZE scale
// engines. One requester owns the stream per pass, chosen round-robin; each
// pass starts with a one-cycle database rewind and runs until database end,
// early reject, requester withdrawal or watchdog expiry.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    haar_db_scheduler_if.slave (requests, rejects, db end in;
//          rewind/enable, grant, done/pass, timeout, busy out)
// All outputs are registered.
// -----------------------------------------------------------------------------
module haar_db_scheduler
  import haar_sched_pkg::*;
#(
  parameter int NUM_RESIZE      = NUM_RESIZE_DEF,
  parameter int IDX_W           = idx_width(NUM_RESIZE),
  parameter int TIMEOUT_W       = 16,
  parameter int MAX_PASS_CYCLES = 40000
) (
  input  logic              clk,
  input  logic              reset,
  haar_db_scheduler_if.slave bus
);

  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'(MAX_PASS_CYCLES - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_RESIZE - 1);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [TIMEOUT_W-1:0]  wdog_q, wdog_d;
  logic [NUM_RESIZE-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_RESIZE-1:0] done_q, done_d;
  logic                  db_reset_q, db_reset_d;
  logic                  db_en_q, db_en_d;
  logic                  pass_q, pass_d;
  logic                  timeout_q, timeout_d;
  logic                  busy_q, busy_d;

  logic [NUM_RESIZE-1:0] pick_gnt;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic                  req_g;
  logic                  rej_g;

  rr_priority_pick #(
    .N     (NUM_RESIZE),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i (bus.i_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Masking with the one-hot grant looks only at the owner's lines, so
  // requests and rejects of other scales are ignored during a pass.
  assign req_g = |(bus.i_req & grant_q);
  assign rej_g = |(bus.i_reject & grant_q);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    wdog_d     = wdog_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    done_d     = '0;
    db_reset_d = 1'b0;
    db_en_d    = 1'b0;
    pass_d     = 1'b0;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = REWIND;
          grant_d    = pick_gnt;
          idx_d      = pick_idx;
          db_reset_d = 1'b1;
        end
      end
      REWIND: begin
        state_d = STREAM;
        db_en_d = 1'b1;
        wdog_d  = '0;
      end
      STREAM: begin
        // Termination priority: withdrawal, reject, database end, watchdog.
        if (!req_g) begin
          state_d = RELEASE;
        end else if (rej_g) begin
          state_d = RELEASE;
          done_d  = grant_q;
        end else if (bus.i_db_end) begin
          state_d = RELEASE;
          done_d  = grant_q;
          pass_d  = 1'b1;
        end else if (wdog_q == WDOG_LAST) begin
          state_d   = RELEASE;
          timeout_d = 1'b1;
        end else begin
          db_en_d = 1'b1;
          if (wdog_q != '1) wdog_d = wdog_q + TIMEOUT_W'(1);
        end
      end
      RELEASE: begin
        state_d  = IDLE;
        grant_d  = '0;
        idx_d    = '0;
        // Restart the search just past the owner so it queues behind others.
        rr_ptr_d = (idx_q >= IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      wdog_q     <= '0;
      grant_q    <= '0;
      idx_q      <= '0;
      done_q     <= '0;
      db_reset_q <= 1'b0;
      db_en_q    <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      wdog_q     <= wdog_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
      db_reset_q <= db_reset_d;
      db_en_q    <= db_en_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.o_db_reset  = db_reset_q;
  assign bus.o_db_en     = db_en_q;
  assign bus.o_grant     = grant_q;
  assign bus.o_grant_idx = idx_q;
  assign bus.o_done      = done_q;
  assign bus.o_pass      = pass_q;
  assign bus.o_timeout   = timeout_q;
  assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_haar_db_scheduler.sv
// -----------------------------------------------------------------------------
// tb_haar_db_scheduler
// Directed bench for haar_db_scheduler with a scoreboard: stimulus pushes the
// expected grant / done / timeout events, a negedge monitor pops and compares
// them as the DUT produces them. Watchdog limit shortened to 8 cycles.
// -----------------------------------------------------------------------------
module tb_haar_db_scheduler;

  localparam int NR   = 5;
  localparam int IW   = 3;
  localparam int TW   = 16;
  localparam int MAXP = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  haar_db_scheduler_if #(.NUM_RESIZE(NR), .IDX_W(IW)) bus ();

  haar_db_scheduler #(
    .NUM_RESIZE      (NR),
    .IDX_W           (IW),
    .TIMEOUT_W       (TW),
    .MAX_PASS_CYCLES (MAXP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef enum int {EV_GRANT = 0, EV_DONE = 1, EV_TIMEOUT = 2} ev_kind_t;
  typedef struct {
    ev_kind_t      kind;
    logic [NR-1:0] vec;
    logic [IW-1:0] idx;
    logic          pass;
  } ev_t;

  ev_t sb[$];
  int  errors = 0;
  int  checks = 0;
  int  db_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [NR-1:0] v, input logic [IW-1:0] i,
                      input logic p);
    ev_t e;
    e.kind = k;
    e.vec  = v;
    e.idx  = i;
    e.pass = p;
    sb.push_back(e);
  endtask

  task automatic take(input ev_kind_t k);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none at %0t", int'(k), $time);
    end else begin
      e = sb.pop_front();
      chk("event_kind", 32'(int'(k)), 32'(int'(e.kind)));
      case (k)
        EV_GRANT: begin
          chk("grant_vec", 32'(bus.o_grant), 32'(e.vec));
          chk("grant_idx", 32'(bus.o_grant_idx), 32'(e.idx));
        end
        EV_DONE: begin
          chk("done_vec", 32'(bus.o_done), 32'(e.vec));
          chk("done_pass", 32'(bus.o_pass), 32'(e.pass));
        end
        default: begin
          chk("timeout_en_cycles", 32'(db_cnt), 32'(MAXP));
        end
      endcase
    end
  endtask

  // Monitor: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.o_db_reset) begin
        db_cnt = 0;
        take(EV_GRANT);
      end
      if (bus.o_done != '0) take(EV_DONE);
      if (bus.o_timeout) take(EV_TIMEOUT);
      if (bus.o_db_en) db_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_stream(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      if (bus.o_db_en) seen = 1'b1;
      else cyc();
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic end_pass(input logic [NR-1:0] v);
    bus.i_db_end = 1'b1;
    push(EV_DONE, v, '0, 1'b1);
    cyc();
    bus.i_db_end = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [NR-1:0] v;
    bit            seen;

    bus.i_req    = '0;
    bus.i_reject = '0;
    bus.i_db_end = 1'b0;

    // Reset state
    repeat (3) cyc();
    chk("rst_grant", 32'(bus.o_grant), 32'd0);
    chk("rst_idx", 32'(bus.o_grant_idx), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_en_reset", 32'({bus.o_db_en, bus.o_db_reset}), 32'd0);
    chk("rst_pulses", 32'({bus.o_done, bus.o_pass, bus.o_timeout}), 32'd0);
    reset = 1'b0;
    cyc();

    // Database end while idle is ignored
    bus.i_db_end = 1'b1;
    cyc();
    bus.i_db_end = 1'b0;
    cyc();
    chk("idle_dbend_busy", 32'(bus.o_busy), 32'd0);
    chk("idle_dbend_en", 32'(bus.o_db_en), 32'd0);

    // Single request: grant+rewind one edge after sampling, enable one later
    bus.i_req = 5'b00100;
    push(EV_GRANT, 5'b00100, 3'd2, 1'b0);
    cyc();
    chk("lat_grant", 32'(bus.o_grant), 32'h04);
    chk("lat_db_reset", 32'(bus.o_db_reset), 32'd1);
    chk("lat_en_low", 32'(bus.o_db_en), 32'd0);
    chk("lat_busy", 32'(bus.o_busy), 32'd1);
    cyc();
    chk("lat_en_high", 32'(bus.o_db_en), 32'd1);
    chk("lat_reset_low", 32'(bus.o_db_reset), 32'd0);
    repeat (2) cyc();
    end_pass(5'b00100);
    chk("single_done", 32'(bus.o_done), 32'h04);
    chk("single_en_drop", 32'(bus.o_db_en), 32'd0);
    chk("release_grant_held", 32'(bus.o_grant), 32'h04);
    bus.i_req = '0;
    cyc();
    chk("idle_grant_clear", 32'(bus.o_grant), 32'd0);
    chk("idle_busy_clear", 32'(bus.o_busy), 32'd0);

    // Round-robin from a cleared pointer: 0,1,2,3,4,0
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.i_req = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      v = '0;
      v[k % NR] = 1'b1;
      push(EV_GRANT, v, IW'(k % NR), 1'b0);
      wait_stream("rr_stream");
      cyc();
      end_pass(v);
      if (k == 5) bus.i_req = '0;
    end
    cyc();

    // Early reject on idx 1 beats a simultaneous database end; a reject on a
    // non-granted index is ignored.
    bus.i_req = 5'b00010;
    push(EV_GRANT, 5'b00010, 3'd1, 1'b0);
    wait_stream("rej_stream");
    bus.i_reject = 5'b01000;
    cyc();
    chk("foreign_reject_ignored", 32'(bus.o_db_en), 32'd1);
    bus.i_reject = 5'b00010;
    bus.i_db_end = 1'b1;
    push(EV_DONE, 5'b00010, '0, 1'b0);
    cyc();
    bus.i_reject = '0;
    bus.i_db_end = 1'b0;
    chk("reject_pass", 32'(bus.o_pass), 32'd0);
    bus.i_req = '0;
    cyc();

    // Withdrawal of idx 3, then idx 0 is served and runs into the watchdog
    bus.i_req = 5'b01001;
    push(EV_GRANT, 5'b01000, 3'd3, 1'b0);
    wait_stream("wd_stream");
    cyc();
    bus.i_req = 5'b00001;
    push(EV_GRANT, 5'b00001, 3'd0, 1'b0);
    cyc();
    chk("withdraw_no_done", 32'(bus.o_done), 32'd0);
    chk("withdraw_en_drop", 32'(bus.o_db_en), 32'd0);
    wait_stream("to_stream");
    push(EV_TIMEOUT, '0, '0, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc();
      if (bus.o_timeout) seen = 1'b1;
    end
    chk("timeout_seen", 32'(seen), 32'd1);
    chk("timeout_no_done", 32'(bus.o_done), 32'd0);
    bus.i_req = '0;
    cyc();

    // Asynchronous reset mid-stream, then the pointer restarts at 0
    bus.i_req = 5'b10000;
    push(EV_GRANT, 5'b10000, 3'd4, 1'b0);
    wait_stream("ar_stream");
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_en", 32'(bus.o_db_en), 32'd0);
    chk("ar_grant", 32'(bus.o_grant), 32'd0);
    chk("ar_busy", 32'(bus.o_busy), 32'd0);
    chk("ar_pulses", 32'({bus.o_done, bus.o_timeout}), 32'd0);
    cyc();
    bus.i_req = 5'b10001;
    reset = 1'b0;
    push(EV_GRANT, 5'b00001, 3'd0, 1'b0);
    wait_stream("post_ar_stream");
    end_pass(5'b00001);
    bus.i_req = '0;
    repeat (4) cyc();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
